// File: rtl/lif_layer.sv
// Layer of N leaky integrate-and-fire neurons with saturating membrane update,
// optional refractory period, and a spike chain from neuron i-1 into neuron i.
module lif_layer #(
    parameter int N            = 2,
    parameter int W            = 8,
    parameter int BETA_SHIFT   = 1,
    parameter int THRESHOLD    = 128,
    parameter int REFRACT      = 0,
    parameter int RESET_MODE   = 0,
    parameter int CHAIN_WEIGHT = 0,
    localparam int SEL_W       = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N*W-1:0]   current,
    input  logic [SEL_W-1:0] sel,
    output logic [N-1:0]     spike,
    output logic [W-1:0]     state_out
);

    localparam logic [W-1:0] MAX_STATE  = {W{1'b1}};
    localparam logic [W-1:0] TH_W       = W'(THRESHOLD);
    localparam logic [W+1:0] CHAIN_EXT  = (W+2)'(CHAIN_WEIGHT);
    localparam logic [3:0]   REFRACT_LD = 4'(REFRACT);

    logic [W-1:0] state_reg [N];
    logic [3:0]   refr_reg  [N];
    logic         spike_reg [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_neuron
            logic [W+1:0] chain;
            logic [W+1:0] sum;
            logic [W-1:0] leak;
            logic [W-1:0] sat;
            logic [W-1:0] fire_state_next;
            logic         fire;

            if (gi == 0) begin : g_head
                assign chain = '0;
            end else begin : g_chain
                // Uses the registered spike of the previous neuron: one cycle of latency.
                assign chain = spike_reg[gi-1] ? CHAIN_EXT : '0;
            end

            assign leak = state_reg[gi] >> BETA_SHIFT;
            // W+2 bits holds three W-bit terms without overflow, so the clamp is exact.
            assign sum  = {2'b00, state_reg[gi]} - {2'b00, leak}
                        + {2'b00, current[gi*W +: W]} + chain;
            assign sat  = (sum > {2'b00, MAX_STATE}) ? MAX_STATE : sum[W-1:0];
            assign fire = (sat >= TH_W);
            assign fire_state_next = (RESET_MODE == 1) ? (sat - TH_W) : '0;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg[gi] <= '0;
                    refr_reg[gi]  <= '0;
                    spike_reg[gi] <= 1'b0;
                end else if (!en) begin
                    spike_reg[gi] <= 1'b0;
                end else if (refr_reg[gi] != 4'd0) begin
                    refr_reg[gi]  <= refr_reg[gi] - 4'd1;
                    spike_reg[gi] <= 1'b0;
                end else if (fire) begin
                    state_reg[gi] <= fire_state_next;
                    refr_reg[gi]  <= REFRACT_LD;
                    spike_reg[gi] <= 1'b1;
                end else begin
                    state_reg[gi] <= sat;
                    spike_reg[gi] <= 1'b0;
                end
            end

            assign spike[gi] = spike_reg[gi];
        end
    endgenerate

    always_comb begin
        state_out = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == SEL_W'(i)) begin
                state_out = state_reg[i];
            end
        end
    end

endmodule

// File: tb/tb_lif_layer.sv
// Directed bench for lif_layer: three instances cover leak/spike, subtract-mode
// saturation, and refractory/chain behaviour against hand-computed values.
module tb_lif_layer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] cur_a, cur_b;
    logic [23:0] cur_c;
    logic [0:0]  sel_a, sel_b;
    logic [1:0]  sel_c;
    logic [1:0]  spike_a, spike_b;
    logic [2:0]  spike_c;
    logic [7:0]  so_a, so_b, so_c;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lif_layer dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .current(cur_a), .sel(sel_a),
        .spike(spike_a), .state_out(so_a)
    );

    lif_layer #(.RESET_MODE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .current(cur_b), .sel(sel_b),
        .spike(spike_b), .state_out(so_b)
    );

    lif_layer #(.N(3), .REFRACT(2), .CHAIN_WEIGHT(200)) dut_c (
        .clk(clk), .rst_n(rst_n), .en(en), .current(cur_c), .sel(sel_c),
        .spike(spike_c), .state_out(so_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
        $display("check %s observed=%0d expected=%0d", tag, obs, exp_v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_a_state", so_a, 0);
        chk("rst_a_spike", spike_a, 0);
        #1;
        rst_n = 1'b1;
    endtask

    int exp_sub [7] = '{20, 30, 35, 38, 39, 40, 40};

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        cur_a = '0; cur_b = '0; cur_c = '0;
        sel_a = '0; sel_b = '0; sel_c = '0;

        // Reset state
        #1;
        chk("reset_state0", so_a, 0);
        sel_a = 1'b1;
        #1;
        chk("reset_state1", so_a, 0);
        chk("reset_spike", spike_a, 0);
        sel_a = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Subthreshold leak convergence
        cur_a = {8'd0, 8'd20};
        for (int k = 0; k < 7; k++) begin
            step();
            chk($sformatf("sub_state_e%0d", k+1), so_a, exp_sub[k]);
            chk($sformatf("sub_spike_e%0d", k+1), spike_a, 0);
        end
        sel_a = 1'b1;
        #1;
        chk("sub_state1_idle", so_a, 0);
        sel_a = 1'b0;

        // Asynchronous reset mid-operation clears accumulated state
        pulse_reset();

        // Spike and reset-to-zero with current 100
        cur_a = {8'd0, 8'd100};
        step(); chk("sp_e1_state", so_a, 100); chk("sp_e1_spike", spike_a, 0);
        step(); chk("sp_e2_state", so_a, 0);   chk("sp_e2_spike", spike_a, 2'b01);
        step(); chk("sp_e3_state", so_a, 100); chk("sp_e3_spike", spike_a, 0);
        step(); chk("sp_e4_state", so_a, 0);   chk("sp_e4_spike", spike_a, 2'b01);
        step(); chk("sp_e5_state", so_a, 100); chk("sp_e5_spike", spike_a, 0);

        // Enable low for three edges freezes state
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("en_off%0d_state", k), so_a, 100);
            chk($sformatf("en_off%0d_spike", k), spike_a, 0);
        end
        en = 1'b1;
        step(); chk("en_on_state", so_a, 0); chk("en_on_spike", spike_a, 2'b01);
        en = 1'b0;
        step(); chk("en_clr_spike", spike_a, 0); chk("en_clr_state", so_a, 0);
        en = 1'b1;
        step(); chk("pre_rst_state", so_a, 100);
        pulse_reset();
        step(); chk("restart_state", so_a, 100); chk("restart_spike", spike_a, 0);

        // Subtract mode with saturation (dut_b)
        cur_a = '0;
        pulse_reset();
        cur_b = {8'd130, 8'd255};
        step();
        chk("sat_e1_state0", so_b, 127);
        chk("sat_e1_spike", spike_b, 2'b11);
        step();
        chk("sat_e2_state0", so_b, 127);
        chk("sat_e2_spike", spike_b, 2'b11);
        sel_b = 1'b1;
        #1;
        chk("sub_e2_state1", so_b, 3);
        cur_b = '0;

        // Out-of-range select reads zero (dut_c)
        pulse_reset();
        cur_c = {8'd0, 8'd0, 8'd50};
        step();
        chk("oor_sel0", so_c, 50);
        sel_c = 2'd3;
        #1;
        chk("oor_sel3", so_c, 0);
        sel_c = 2'd0;

        // Refractory and chain propagation
        pulse_reset();
        cur_c = {8'd0, 8'd0, 8'd200};
        step(); chk("rf_e1_spike", spike_c, 3'b001); chk("rf_e1_state0", so_c, 0);
        step(); chk("rf_e2_spike", spike_c, 3'b010); chk("rf_e2_state0", so_c, 0);
        step(); chk("rf_e3_spike", spike_c, 3'b100); chk("rf_e3_state0", so_c, 0);
        step(); chk("rf_e4_spike", spike_c, 3'b001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lif_layer.md
LIF_LAYER -- requirements
Module: lif_layer

Interface
REQ-001 Parameter N, default 2: number of neuron channels, 1..16.
REQ-002 Parameter W, default 8: membrane state and current width in bits, 4..16.
REQ-003 Parameter BETA_SHIFT, default 1: leak is computed as state >> BETA_SHIFT, range 1..W-1.
REQ-004 Parameter THRESHOLD, default 128: spike threshold, range 1..2^W-1.
REQ-005 Parameter REFRACT, default 0: refractory cycles after a spike, range 0..15.
REQ-006 Parameter RESET_MODE, default 0: post-spike state rule; 0 sets state to zero, 1 subtracts THRESHOLD.
REQ-007 Parameter CHAIN_WEIGHT, default 0: value added to neuron i (i>0) when neuron i-1 spiked in the previous cycle, range 0..2^W-1.
REQ-008 clk  input  1  single clock; all state updates on the rising edge.
REQ-009 rst_n  input  1  asynchronous, active-low reset.
REQ-010 en  input  1  update enable; when low, all registers hold.
REQ-011 current  input  N*W  per-neuron input current, unsigned; neuron i uses bits [i*W +: W].
REQ-012 sel  input  clog2(N) (minimum 1)  selects the neuron driven on state_out.
REQ-013 spike  output  N  registered one-cycle spike pulse per neuron.
REQ-014 state_out  output  W  membrane state of neuron sel, combinational mux of registered states; out-of-range sel outputs 0.

Function
REQ-015 Each enabled rising edge with neuron i not refractory computes sum = state - (state >> BETA_SHIFT) + current_i + chain_i at W+2 bits, where chain_i = CHAIN_WEIGHT if i>0 and spike[i-1]=1, otherwise 0.
REQ-016 sum saturates to 2^W-1 before the threshold compare; there is no wrap-around.
REQ-017 If the saturated sum >= THRESHOLD: spike[i] is set to 1 for that cycle, state becomes 0 (RESET_MODE=0) or sum-THRESHOLD (RESET_MODE=1), and the refractory counter is loaded with REFRACT.
REQ-018 If the saturated sum < THRESHOLD: state becomes the saturated sum and spike[i] is set to 0.
REQ-019 While refractory counter > 0 on an enabled edge: state holds, current and chain inputs are ignored, spike[i] is 0, and the counter decrements by 1.
REQ-020 With REFRACT=0, a neuron can spike on consecutive enabled edges.
REQ-021 On an edge with en=0: state and counters hold, and all spike bits clear to 0, so spike is never more than one cycle wide.
REQ-022 Chain input uses the registered spike[i-1], giving one cycle of latency from the neuron i-1 spike to the neuron i contribution.
REQ-023 Latency from current to the updated state or spike is one clock.
REQ-024 All neurons update in parallel and independently, apart from the chain term.

Reset
REQ-025 When rst_n=0, all states, refractory counters and spike bits clear to 0 immediately, independent of clk.
REQ-026 Reset asserted mid-operation discards any pending refractory count and accumulated state; the first enabled edge after deassertion uses state=0.
REQ-027 During reset, state_out reads 0 for every sel.

Verification
REQ-028 Subthreshold: N=2, W=8, BETA_SHIFT=1, THRESHOLD=128, current0=20 held -> state0 sequence 20,30,35,38,39,40,40...; spike0 stays 0.
REQ-029 Spike and reset-to-zero: current0=100 from reset -> state0 = 100, then 0 with spike0=1 on edge 2 (sum 150), then 100, then 0 with a spike again; the spike is one cycle wide.
REQ-030 Saturation and subtract mode: RESET_MODE=1, state0=255, current0=255 -> sum saturates to 255, spike0=1, state0=127.
REQ-031 Refractory: REFRACT=2, current0=200 -> spike on edge 1, state held at 0 on edges 2 and 3, next spike no earlier than edge 4.
REQ-032 Chain: CHAIN_WEIGHT=200, current1=0, neuron 0 spikes on edge t -> state1 = 200 and spike1=1 on edge t+1.
REQ-033 Enable and reset: en=0 for 3 cycles mid-sequence -> state frozen and spike 0; rst_n pulsed low between edges -> all outputs 0 immediately and the sequence restarts from 0.
